// File: rtl/sc_phase_ctrl.sv
// Two-phase non-overlapping clock controller: bias enable, settling wait, then phi1/phi1e/phi2 with dead time.
// Latency: bias_en one cycle after en is sampled; phi1 SETTLE_CYC cycles later; all outputs registered.
// Backpressure: none; en is a level run request and a started period always runs through DEAD21.
module sc_phase_ctrl #(
   parameter int SETTLE_CYC = 64,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] cfg_ph_len,
   input  logic [3:0]       cfg_dead,
   input  logic [3:0]       cfg_early,
   output logic             bias_en,
   output logic             phi1,
   output logic             phi1e,
   output logic             phi2,
   output logic             ready,
   output logic             sample_stb,
   output logic [15:0]      period_cnt
);

   // Down-counter must hold SETTLE_CYC-1, L-1 and D-1.
   localparam int SW  = $clog2(SETTLE_CYC + 1);
   localparam int TW0 = (CNT_W > 4) ? CNT_W : 4;
   localparam int TW  = (SW > TW0) ? SW : TW0;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SETTLE = 3'd1;
   localparam logic [2:0] PHI1   = 3'd2;
   localparam logic [2:0] DEAD12 = 3'd3;
   localparam logic [2:0] PHI2   = 3'd4;
   localparam logic [2:0] DEAD21 = 3'd5;

   localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);
   localparam logic [TW-1:0]    T_ONE     = TW'(1);
   localparam logic [TW-1:0]    SETTLE_LD = TW'(SETTLE_CYC - 1);

   logic [2:0]       state, nstate;
   logic [TW-1:0]    cnt, cnt_nxt;
   logic [CNT_W-1:0] len_q, len_nxt, len_in;
   logic [3:0]       dead_q, dead_nxt, dead_in;
   logic [CNT_W-1:0] early_q, early_nxt, early_in, early_ext;
   logic             enter_phi1;
   logic             stb_nxt;

   // Clamp the live config: L >= 1, D >= 1, E <= L-1 so phi1e is high for at least one cycle.
   always_comb begin
      len_in    = (cfg_ph_len == '0) ? L_ONE : cfg_ph_len;
      dead_in   = (cfg_dead == 4'd0) ? 4'd1 : cfg_dead;
      early_ext = CNT_W'(cfg_early);
      early_in  = (early_ext > (len_in - L_ONE)) ? (len_in - L_ONE) : early_ext;
   end

   // Next state and phase counter; config is captured only when a period starts.
   always_comb begin
      nstate     = state;
      cnt_nxt    = cnt;
      len_nxt    = len_q;
      dead_nxt   = dead_q;
      early_nxt  = early_q;
      enter_phi1 = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               nstate  = SETTLE;
               cnt_nxt = SETTLE_LD;
            end
         end
         SETTLE: begin
            if (!en) begin
               nstate  = IDLE;
               cnt_nxt = '0;
            end else if (cnt == '0) begin
               enter_phi1 = 1'b1;
            end else begin
               cnt_nxt = cnt - T_ONE;
            end
         end
         PHI1: begin
            if (cnt == '0) begin
               nstate  = DEAD12;
               cnt_nxt = TW'(dead_q - 4'd1);
            end else begin
               cnt_nxt = cnt - T_ONE;
            end
         end
         DEAD12: begin
            if (cnt == '0) begin
               nstate  = PHI2;
               cnt_nxt = TW'(len_q - L_ONE);
            end else begin
               cnt_nxt = cnt - T_ONE;
            end
         end
         PHI2: begin
            if (cnt == '0) begin
               nstate  = DEAD21;
               cnt_nxt = TW'(dead_q - 4'd1);
            end else begin
               cnt_nxt = cnt - T_ONE;
            end
         end
         DEAD21: begin
            if (cnt == '0) begin
               if (en) begin
                  enter_phi1 = 1'b1;
               end else begin
                  nstate  = IDLE;
                  cnt_nxt = '0;
               end
            end else begin
               cnt_nxt = cnt - T_ONE;
            end
         end
         default: begin
            nstate  = IDLE;
            cnt_nxt = '0;
         end
      endcase
      if (enter_phi1) begin
         nstate    = PHI1;
         len_nxt   = len_in;
         dead_nxt  = dead_in;
         early_nxt = early_in;
         cnt_nxt   = TW'(len_in - L_ONE);
      end
      stb_nxt = (nstate == DEAD21) && (state != DEAD21);
   end

   // State, latched config and outputs decoded from next state so every output is a clean flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         len_q      <= L_ONE;
         dead_q     <= 4'd1;
         early_q    <= '0;
         bias_en    <= 1'b0;
         phi1       <= 1'b0;
         phi1e      <= 1'b0;
         phi2       <= 1'b0;
         ready      <= 1'b0;
         sample_stb <= 1'b0;
         period_cnt <= 16'd0;
      end else begin
         state      <= nstate;
         cnt        <= cnt_nxt;
         len_q      <= len_nxt;
         dead_q     <= dead_nxt;
         early_q    <= early_nxt;
         bias_en    <= (nstate != IDLE);
         phi1       <= (nstate == PHI1);
         // Counter runs L-1..0 in PHI1, so cnt >= E covers exactly the first L-E cycles.
         phi1e      <= (nstate == PHI1) && (cnt_nxt >= TW'(early_nxt));
         phi2       <= (nstate == PHI2);
         ready      <= (nstate == PHI1) || (nstate == DEAD12) ||
                       (nstate == PHI2) || (nstate == DEAD21);
         sample_stb <= stb_nxt;
         if (stb_nxt) begin
            period_cnt <= period_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_sc_phase_ctrl.sv
// Testbench for sc_phase_ctrl: directed scenarios plus randomized run against a queue-based waveform model.
// Latency: model predicts the outputs visible after each rising edge.
// Backpressure: not applicable.
module tb_sc_phase_ctrl;
   localparam int SETTLE = 16;
   localparam int CW     = 8;

   logic          clk = 1'b0;
   logic          rst, en;
   logic [CW-1:0] cfg_ph_len;
   logic [3:0]    cfg_dead, cfg_early;
   logic          bias_en, phi1, phi1e, phi2, ready, sample_stb;
   logic [15:0]   period_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   sc_phase_ctrl #(.SETTLE_CYC(SETTLE), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .en(en),
      .cfg_ph_len(cfg_ph_len), .cfg_dead(cfg_dead), .cfg_early(cfg_early),
      .bias_en(bias_en), .phi1(phi1), .phi1e(phi1e), .phi2(phi2),
      .ready(ready), .sample_stb(sample_stb), .period_cnt(period_cnt)
   );

   wire [5:0] dut_vec = {bias_en, phi1, phi1e, phi2, ready, sample_stb};

   // Reference model: a queue of per-cycle output vectors {bias,phi1,phi1e,phi2,ready,stb}.
   logic [5:0]  m_q[$];
   logic [5:0]  exp_vec = 6'd0;
   logic [15:0] exp_cnt = 16'd0;
   int          m_mode  = 0;   // 0 idle, 1 settling, 2 running

   task automatic push_period();
      int l, d, e;
      l = (cfg_ph_len == 0) ? 1 : int'(cfg_ph_len);
      d = (cfg_dead == 0) ? 1 : int'(cfg_dead);
      e = int'(cfg_early);
      if (e > l - 1) e = l - 1;
      for (int i = 0; i < l; i++) m_q.push_back({1'b1, 1'b1, (i < l - e), 1'b0, 1'b1, 1'b0});
      for (int i = 0; i < d; i++) m_q.push_back(6'b100010);
      for (int i = 0; i < l; i++) m_q.push_back(6'b100110);
      for (int i = 0; i < d; i++) m_q.push_back((i == 0) ? 6'b100011 : 6'b100010);
   endtask

   task automatic model_step();
      logic [5:0] v;
      if (rst) begin
         m_q.delete();
         m_mode  = 0;
         exp_cnt = 16'd0;
         exp_vec = 6'd0;
         return;
      end
      if (m_mode == 1 && !en) begin
         m_q.delete();
         m_mode = 0;
      end
      if (m_q.size() == 0) begin
         if (m_mode == 0) begin
            if (en) begin
               repeat (SETTLE) m_q.push_back(6'b100000);
               m_mode = 1;
            end
         end else if (m_mode == 1 || en) begin
            push_period();
            m_mode = 2;
         end else begin
            m_mode = 0;
         end
      end
      if (m_q.size() > 0) v = m_q.pop_front();
      else v = 6'd0;
      exp_vec = v;
      if (v[0]) exp_cnt = exp_cnt + 16'd1;
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      #1;
   endtask

   function automatic logic sig_of(input int sel);
      case (sel)
         0:       return phi1;
         1:       return phi2;
         2:       return bias_en;
         default: return ready;
      endcase
   endfunction

   task automatic wait_sig(input int sel, input logic lvl, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (sig_of(sel) === lvl) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0;
      cfg_ph_len = 8'd4; cfg_dead = 4'd2; cfg_early = 4'd1;
      repeat (3) tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (dut_vec !== 6'd0 || period_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: outputs %b cnt %0d, expected 000000 cnt 0", cyc, dut_vec, period_cnt);
         end
      end
   endtask

   task automatic test_startup();
      int n, c1, ce, c2, cs;
      en = 1'b1;
      tick();
      checks++;
      if (bias_en !== 1'b1 || phi1 !== 1'b0) begin
         errors++;
         $display("FAIL startup_bias: bias_en %b phi1 %b, expected 1 0", bias_en, phi1);
      end
      n = 0;
      while (phi1 !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (n != SETTLE) begin
         errors++;
         $display("FAIL startup_delay: phi1 after %0d cycles, expected %0d", n, SETTLE);
      end
      c1 = 0; ce = 0; c2 = 0; cs = 0;
      for (int i = 0; i < 60; i++) begin
         if (i > 0) tick();
         c1 += int'(phi1); ce += int'(phi1e); c2 += int'(phi2); cs += int'(sample_stb);
         checks++;
         if (dut_vec !== exp_vec || period_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL startup_model cyc %0d: got %b/%0d expected %b/%0d", cyc, dut_vec, period_cnt, exp_vec, exp_cnt);
         end
      end
      checks++;
      if (c1 != 20 || ce != 15 || c2 != 20 || cs != 5) begin
         errors++;
         $display("FAIL startup_counts: phi1 %0d phi1e %0d phi2 %0d stb %0d, expected 20 15 20 5", c1, ce, c2, cs);
      end
      checks++;
      if (period_cnt !== 16'd5) begin
         errors++;
         $display("FAIL startup_period_cnt: %0d, expected 5", period_cnt);
      end
   endtask

   task automatic test_cfg_change();
      bit ok0, ok1, ok2, ok3, ok4, ok5;
      int p0, p1, p2;
      wait_sig(0, 1'b0, 50, ok0);
      wait_sig(0, 1'b1, 50, ok1);
      p0 = cyc;
      wait_sig(1, 1'b1, 50, ok2);
      cfg_ph_len = 8'd6;
      wait_sig(0, 1'b0, 50, ok3);
      wait_sig(0, 1'b1, 50, ok4);
      p1 = cyc;
      wait_sig(0, 1'b0, 50, ok5);
      wait_sig(0, 1'b1, 50, ok0);
      p2 = cyc;
      checks++;
      if (!(ok0 && ok1 && ok2 && ok3 && ok4 && ok5)) begin
         errors++;
         $display("FAIL cfg_change_wait: phase edge not seen within budget");
      end
      checks++;
      if (p1 - p0 != 12) begin
         errors++;
         $display("FAIL cfg_change_cur_period: %0d cycles, expected 12", p1 - p0);
      end
      checks++;
      if (p2 - p1 != 16) begin
         errors++;
         $display("FAIL cfg_change_next_period: %0d cycles, expected 16", p2 - p1);
      end
   endtask

   task automatic test_clamp();
      int last_stb;
      cfg_ph_len = 8'd0; cfg_dead = 4'd0; cfg_early = 4'd9;
      last_stb = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec || period_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL clamp_model cyc %0d: got %b/%0d expected %b/%0d", cyc, dut_vec, period_cnt, exp_vec, exp_cnt);
         end
         checks++;
         if ((phi1 & phi2) !== 1'b0) begin
            errors++;
            $display("FAIL clamp_overlap cyc %0d: phi1 %b phi2 %b, expected not both 1", cyc, phi1, phi2);
         end
         if (i >= 20) begin
            checks++;
            if (phi1e !== phi1) begin
               errors++;
               $display("FAIL clamp_phi1e cyc %0d: phi1e %b, expected phi1 %b", cyc, phi1e, phi1);
            end
            if (sample_stb === 1'b1) begin
               if (last_stb >= 0) begin
                  checks++;
                  if (cyc - last_stb != 4) begin
                     errors++;
                     $display("FAIL clamp_period: %0d cycles, expected 4", cyc - last_stb);
                  end
               end
               last_stb = cyc;
            end
         end
      end
   endtask

   task automatic test_stop();
      bit ok0, ok1;
      int nstb, stb_cyc, fall;
      cfg_ph_len = 8'd4; cfg_dead = 4'd2; cfg_early = 4'd1;
      wait_sig(0, 1'b0, 50, ok0);
      wait_sig(0, 1'b1, 50, ok1);
      en = 1'b0;
      nstb = 0; stb_cyc = -100; fall = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec || period_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL stop_model cyc %0d: got %b/%0d expected %b/%0d", cyc, dut_vec, period_cnt, exp_vec, exp_cnt);
         end
         if (sample_stb === 1'b1) begin
            nstb++;
            stb_cyc = cyc;
         end
         if (bias_en === 1'b0) begin
            fall = cyc;
            break;
         end
      end
      checks++;
      if (!(ok0 && ok1) || fall < 0) begin
         errors++;
         $display("FAIL stop_wait: waits %b%b bias fall cycle %0d", ok0, ok1, fall);
      end
      checks++;
      if (nstb != 1) begin
         errors++;
         $display("FAIL stop_stb_count: %0d, expected 1", nstb);
      end
      checks++;
      if (fall - stb_cyc != 2 || ready !== 1'b0) begin
         errors++;
         $display("FAIL stop_fall: %0d cycles after stb ready %b, expected 2 cycles ready 0", fall - stb_cyc, ready);
      end
   endtask

   task automatic test_settle_abort();
      en = 1'b1;
      tick();
      checks++;
      if (bias_en !== 1'b1) begin
         errors++;
         $display("FAIL abort_bias_rise: bias_en %b, expected 1", bias_en);
      end
      en = 1'b0;
      tick();
      checks++;
      if (bias_en !== 1'b0) begin
         errors++;
         $display("FAIL abort_bias_fall: bias_en %b, expected 0", bias_en);
      end
      for (int i = 0; i < 30; i++) begin
         tick();
         checks++;
         if (dut_vec !== 6'd0 || dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL abort_quiet cyc %0d: got %b expected %b", cyc, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      en = 1'b1;
      wait_sig(1, 1'b1, 100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rstmid_wait: phi2 %b, expected 1 within budget", phi2);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (dut_vec !== 6'd0 || period_cnt !== 16'd0) begin
         errors++;
         $display("FAIL rstmid_clear: outputs %b cnt %0d, expected 000000 cnt 0", dut_vec, period_cnt);
      end
      tick();
      checks++;
      if (bias_en !== 1'b1 || phi1 !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_restart_bias: bias_en %b phi1 %b, expected 1 0", bias_en, phi1);
      end
      n = 0;
      while (phi1 !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (n != SETTLE || period_cnt !== 16'd0) begin
         errors++;
         $display("FAIL rstmid_restart_delay: %0d cycles cnt %0d, expected %0d cnt 0", n, period_cnt, SETTLE);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 3) en = ~en;
         if ($urandom_range(0, 99) < 8) begin
            cfg_ph_len = 8'($urandom_range(0, 7));
            cfg_dead   = 4'($urandom_range(0, 4));
            cfg_early  = 4'($urandom_range(0, 15));
         end
         rst = ($urandom_range(0, 999) < 3);
         tick();
         checks++;
         if (dut_vec !== exp_vec || period_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL random_model cyc %0d: got %b/%0d expected %b/%0d", cyc, dut_vec, period_cnt, exp_vec, exp_cnt);
         end
         checks++;
         if ((phi1 & phi2) !== 1'b0) begin
            errors++;
            $display("FAIL random_overlap cyc %0d: phi1 %b phi2 %b, expected not both 1", cyc, phi1, phi2);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0;
      cfg_ph_len = 8'd4; cfg_dead = 4'd2; cfg_early = 4'd1;
      test_reset();
      test_startup();
      test_cfg_change();
      test_clamp();
      test_stop();
      test_settle_abort();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
